// File: rtl/spi_cmd_log_pkg.sv
// Shared definitions for the SPI command logger: register offsets, the
// log entry layout and a helper that slices an entry into bus words.
package spi_cmd_log_pkg;

    localparam int TS_W   = 24;
    localparam int CMD_W  = 8;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 12;

    localparam logic [7:0] REG_STATUS = 8'h00;
    localparam logic [7:0] REG_HEAD0  = 8'h04;
    localparam logic [7:0] REG_HEAD1  = 8'h08;
    localparam logic [7:0] REG_HEAD2  = 8'h0C;
    localparam logic [7:0] REG_POP    = 8'h10;
    localparam logic [7:0] REG_CLEAR  = 8'h14;

    localparam logic [31:0] RDATA_DEFAULT = 32'hDECAFBAD;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } log_entry_t;

    function automatic logic [31:0] entry_word(input log_entry_t e, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = {e.ts, e.cmd};
            2'd1:    w = e.addr;
            2'd2:    w = {20'h0_0000, e.len};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Generic synchronous FIFO: synchronous-read RAM with a one-entry write
// bypass so the head word is valid the cycle after any push or pop.
module spi_cmd_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 76
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_rd_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             byp_q, byp_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;
    logic             pop_eff_s, push_eff_s;

    // Pointer/count next-state; a write landing on the next head slot goes via bypass.
    always_comb begin
        pop_eff_s  = pop && !empty_q && !clear;
        push_eff_s = push && (!full_q || pop_eff_s) && !clear;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_eff_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_eff_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == {CW{1'b0}});
        byp_d      = push_eff_s && (wr_ptr_q == rd_ptr_d);
        if (push_eff_s) begin
            byp_data_d = wdata;
        end else begin
            byp_data_d = byp_data_q;
        end
    end

    // Storage array and its registered read port (no reset, BRAM style).
    always_ff @(posedge clk) begin
        if (push_eff_s) begin
            mem[wr_ptr_q] <= wdata;
        end
        ram_rd_q <= mem[rd_ptr_d];
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            byp_q      <= 1'b0;
            byp_data_q <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign head  = byp_q ? byp_data_q : ram_rd_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/spi_cmd_log.sv
// SPI command logger: timestamps decoded commands into a FIFO and exposes
// it to firmware through an iomem register window.
module spi_cmd_log
    import spi_cmd_log_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cmd_strobe,
    input  logic [CMD_W-1:0]  spi_cmd,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [LEN_W-1:0]  spi_len,
    input  logic              sel,
    input  logic              iomem_valid,
    input  logic [3:0]        iomem_wstrb,
    input  logic [7:0]        iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic              iomem_ready,
    output logic [31:0]       iomem_rdata,
    output logic              irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [15:0]     drop_q, drop_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            accept_s, write_s, pop_req_s, clear_req_s, drop_s;
    logic [31:0]     status_s, rd_mux_s;
    log_entry_t      entry_s, head_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_full_s, fifo_empty_s;
    logic            unused_wdata_s;

    assign unused_wdata_s = ^iomem_wdata;
    assign entry_s = '{ts: ts_q, cmd: spi_cmd, addr: spi_addr, len: spi_len};

    spi_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(log_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (spi_cmd_strobe),
        .pop   (pop_req_s),
        .clear (clear_req_s),
        .wdata (entry_s),
        .head  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Timestamp prescaler and the drop counter.
    always_comb begin
        presc_d = presc_q;
        ts_d    = ts_q;
        drop_d  = drop_q;
        if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d = {PW{1'b0}};
            ts_d    = ts_q + TS_W'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            ts_d    = ts_q;
        end
        // A pop in the same cycle frees a slot, so only a strobe into a full, unpopped FIFO drops.
        drop_s = spi_cmd_strobe && !clear_req_s && fifo_full_s && !pop_req_s;
        if (clear_req_s) begin
            drop_d = 16'h0000;
        end else if (drop_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'h0001;
        end else begin
            drop_d = drop_q;
        end
    end

    // Register read mux, evaluated on the acceptance cycle.
    always_comb begin
        status_s        = 32'h0000_0000;
        status_s[8:0]   = 9'(fifo_count_s);
        status_s[9]     = fifo_empty_s;
        status_s[10]    = fifo_full_s;
        status_s[31:16] = drop_q;
        rd_mux_s        = RDATA_DEFAULT;
        case (iomem_addr)
            REG_STATUS: rd_mux_s = status_s;
            REG_HEAD0:  rd_mux_s = fifo_empty_s ? 32'h0000_0000 : entry_word(head_s, 2'd0);
            REG_HEAD1:  rd_mux_s = fifo_empty_s ? 32'h0000_0000 : entry_word(head_s, 2'd1);
            REG_HEAD2:  rd_mux_s = fifo_empty_s ? 32'h0000_0000 : entry_word(head_s, 2'd2);
            REG_POP:    rd_mux_s = 32'h0000_0000;
            REG_CLEAR:  rd_mux_s = 32'h0000_0000;
            default:    rd_mux_s = RDATA_DEFAULT;
        endcase
    end

    // Bus handshake and write decode.
    always_comb begin
        accept_s    = iomem_valid && sel && !ready_q;
        write_s     = (iomem_wstrb != 4'h0);
        pop_req_s   = accept_s && write_s && (iomem_addr == REG_POP);
        clear_req_s = accept_s && write_s && (iomem_addr == REG_CLEAR);
        ready_d     = accept_s;
        if (accept_s && !write_s) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= {PW{1'b0}};
            ts_q    <= {TS_W{1'b0}};
            drop_q  <= 16'h0000;
            ready_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
            drop_q  <= drop_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = !fifo_empty_s;

endmodule

// File: tb/tb_spi_cmd_log.sv
// Self-checking bench for spi_cmd_log: random commands checked against a
// queue-based model of the log, with directed bus accesses.
module tb_spi_cmd_log;

    localparam int DEPTH    = 32;
    localparam int TICK_DIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cmd_strobe;
    logic [7:0]  spi_cmd;
    logic [31:0] spi_addr;
    logic [11:0] spi_len;
    logic        sel;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [7:0]  iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    always #5 clk = ~clk;

    spi_cmd_log #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_cmd_strobe (spi_cmd_strobe),
        .spi_cmd        (spi_cmd),
        .spi_addr       (spi_addr),
        .spi_len        (spi_len),
        .sel            (sel),
        .iomem_valid    (iomem_valid),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_addr     (iomem_addr),
        .iomem_wdata    (iomem_wdata),
        .iomem_ready    (iomem_ready),
        .iomem_rdata    (iomem_rdata),
        .irq            (irq)
    );

    // Clock edges since reset released; the timestamp is derived from it.
    int k;
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] mq0[$], mq1[$], mq2[$];
    int          m_drops = 0;
    int          ts_base = 0;
    int          k_base  = 0;
    logic [31:0] s_w0, s_w1, s_w2;
    logic [31:0] rd;
    logic [31:0] tmp;
    int          k0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ts_at(input int kk);
        logic [31:0] t;
        t = 32'(ts_base + (kk - k_base) / TICK_DIV);
        return t[23:0];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [8:0]  c;
        logic [15:0] d;
        c = 9'(mq0.size());
        d = 16'(m_drops);
        return {d, 5'd0, (mq0.size() == DEPTH), (mq0.size() == 0), c};
    endfunction

    function automatic logic [31:0] exp_head(input int idx);
        if (mq0.size() == 0) return 32'h0;
        if (idx == 0) return mq0[0];
        if (idx == 1) return mq1[0];
        return mq2[0];
    endfunction

    // Log semantics: clear discards everything; otherwise pop first, then push or drop.
    task automatic m_apply(input bit strb, input bit pop, input bit clr);
        if (clr) begin
            mq0.delete(); mq1.delete(); mq2.delete();
            m_drops = 0;
        end else begin
            if (pop && mq0.size() > 0) begin
                void'(mq0.pop_front()); void'(mq1.pop_front()); void'(mq2.pop_front());
            end
            if (strb) begin
                if (mq0.size() < DEPTH) begin
                    mq0.push_back(s_w0); mq1.push_back(s_w1); mq2.push_back(s_w2);
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
        end
    endtask

    task automatic prep(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        spi_cmd = c; spi_addr = a; spi_len = l; spi_cmd_strobe = 1'b1;
        s_w0 = {ts_at(k), c}; s_w1 = a; s_w2 = {20'h0, l};
    endtask

    task automatic do_strobe();
        prep(8'($urandom_range(0, 255)), $urandom, 12'($urandom_range(0, 4095)));
        @(negedge clk);
        spi_cmd_strobe = 1'b0;
        m_apply(1'b1, 1'b0, 1'b0);
    endtask

    task automatic bus(input logic [7:0] a, input logic [3:0] ws, input bit strb, output logic [31:0] r);
        bit is_pop, is_clr;
        iomem_valid = 1'b1; sel = 1'b1; iomem_addr = a; iomem_wstrb = ws;
        iomem_wdata = $urandom;
        if (strb) prep(8'($urandom_range(0, 255)), $urandom, 12'($urandom_range(0, 4095)));
        @(negedge clk);
        iomem_valid = 1'b0; sel = 1'b0; spi_cmd_strobe = 1'b0;
        is_pop = (ws != 4'h0) && (a == 8'h10);
        is_clr = (ws != 4'h0) && (a == 8'h14);
        m_apply(strb, is_pop, is_clr);
        check("ready", {31'd0, iomem_ready}, 32'd1);
        r = iomem_rdata;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(a, 4'h0, 1'b0, r);
        check(tag, r, exp);
    endtask

    task automatic wr(input logic [7:0] a, input bit strb);
        logic [31:0] r;
        bus(a, 4'($urandom_range(1, 15)), strb, r);
    endtask

    task automatic chk_heads(input string tag);
        rd_chk({tag, "_h0"}, 8'h04, exp_head(0));
        rd_chk({tag, "_h1"}, 8'h08, exp_head(1));
        rd_chk({tag, "_h2"}, 8'h0C, exp_head(2));
    endtask

    initial begin
        reset = 1'b1; spi_cmd_strobe = 1'b0; spi_cmd = 8'h0; spi_addr = 32'h0; spi_len = 12'h0;
        sel = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 8'h0; iomem_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        rd_chk("status_rst", 8'h00, 32'h0000_0200);
        rd_chk("head0_empty", 8'h04, 32'h0);
        rd_chk("bad_off", 8'h20, 32'hDECAFBAD);
        rd_chk("bad_off2", 8'h18, 32'hDECAFBAD);
        check("irq_empty", {31'd0, irq}, 32'd0);

        // Request with sel low must get no response.
        iomem_valid = 1'b1; sel = 1'b0; iomem_addr = 8'h00; iomem_wstrb = 4'h0;
        @(negedge clk);
        check("nosel_ready0", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        check("nosel_ready1", {31'd0, iomem_ready}, 32'd0);
        iomem_valid = 1'b0;
        @(negedge clk);

        while (k < 5 * TICK_DIV) @(negedge clk);
        prep(8'h03, 32'h0012_3456, 12'h100);
        @(negedge clk);
        spi_cmd_strobe = 1'b0;
        m_apply(1'b1, 1'b0, 1'b0);
        check("irq_one", {31'd0, irq}, 32'd1);
        rd_chk("status_one", 8'h00, exp_status());
        chk_heads("one");
        rd_chk("head1_fixed", 8'h08, 32'h0012_3456);
        wr(8'h00, 1'b0);
        rd_chk("status_ro_wr", 8'h00, exp_status());
        wr(8'h10, 1'b0);
        rd_chk("status_popped", 8'h00, 32'h0000_0200);
        check("irq_popped", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 34; i++) do_strobe();
        rd_chk("status_full", 8'h00, 32'h0002_0420);
        for (int i = 0; i < 32; i++) begin
            chk_heads("drain");
            wr(8'h10, 1'b0);
        end
        rd_chk("status_drained", 8'h00, exp_status());
        check("irq_drained", {31'd0, irq}, 32'd0);
        rd_chk("pop_read", 8'h10, 32'h0);
        rd_chk("clear_read", 8'h14, 32'h0);
        wr(8'h10, 1'b0);
        rd_chk("pop_empty", 8'h00, exp_status());

        for (int i = 0; i < 32; i++) do_strobe();
        wr(8'h10, 1'b1);
        rd_chk("status_full_pp", 8'h00, exp_status());
        for (int i = 0; i < 32; i++) begin
            chk_heads("pp");
            wr(8'h10, 1'b0);
        end
        wr(8'h10, 1'b1);
        rd_chk("status_empty_pp", 8'h00, exp_status());
        chk_heads("empty_pp");
        wr(8'h10, 1'b0);

        for (int i = 0; i < 32; i++) do_strobe();
        force dut.drop_q = 16'hFFF0;
        @(negedge clk);
        release dut.drop_q;
        m_drops = 32'h0000_FFF0;
        for (int i = 0; i < 20; i++) do_strobe();
        rd_chk("drop_sat", 8'h00, 32'hFFFF_0420);
        wr(8'h14, 1'b1);
        rd_chk("status_clear", 8'h00, 32'h0000_0200);
        for (int i = 0; i < 3; i++) do_strobe();
        wr(8'h14, 1'b1);
        rd_chk("clear_strobe", 8'h00, 32'h0000_0200);

        while (k % TICK_DIV != 0) @(negedge clk);
        k0 = k;
        force dut.ts_q = 24'hFFFFFF;
        @(negedge clk);
        release dut.ts_q;
        ts_base = 32'h00FF_FFFF;
        k_base  = k0;
        while (k < k0 + TICK_DIV - 1) @(negedge clk);
        do_strobe();
        do_strobe();
        chk_heads("ts_pre");
        wr(8'h10, 1'b0);
        chk_heads("ts_post");
        tmp = exp_head(0);
        rd_chk("ts_zero", 8'h04, {24'h0, tmp[7:0]});
        wr(8'h10, 1'b0);

        do_strobe();
        do_strobe();
        iomem_valid = 1'b1; sel = 1'b1; iomem_addr = 8'h00; iomem_wstrb = 4'h0; reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready0", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        check("rst_mid_ready1", {31'd0, iomem_ready}, 32'd0);
        iomem_valid = 1'b0; sel = 1'b0; reset = 1'b0;
        m_apply(1'b0, 1'b0, 1'b1);
        ts_base = 0; k_base = 0;
        @(negedge clk);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_mid_status", 8'h00, 32'h0000_0200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
